// File: rtl/mux4_stim_checker.sv
// mux4_stim_checker: sweeps all 64 (D,S) combinations into a 4:1 mux under
// test, samples its output Q once per vector, and counts mismatches against
// the ideal D[S]. All outputs come straight from registers.
module mux4_stim_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       Q,
    output logic [1:0] S,
    output logic [3:0] D,
    output logic       BUSY,
    output logic       DONE,
    output logic       MISMATCH,
    output logic [6:0] ERR_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    // Ideal 4:1 mux reference.
    function automatic logic mux_ref(input logic [3:0] d_v, input logic [1:0] s_v);
        logic r;
        case (s_v)
            2'd0:    r = d_v[0];
            2'd1:    r = d_v[1];
            2'd2:    r = d_v[2];
            2'd3:    r = d_v[3];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] hold_q;
    logic [1:0]       s_q;
    logic [3:0]       d_q;
    logic             busy_q;
    logic             done_q;
    logic             mismatch_q;
    logic [6:0]       err_q;

    logic             sample_s;
    logic             miss_s;
    logic             last_s;
    logic [CNT_W-1:0] hold_d;
    logic [1:0]       s_d;
    logic [3:0]       d_d;
    logic [6:0]       err_d;

    // Sample-edge decode, comparison against the ideal mux, and vector advance.
    always_comb begin
        sample_s = (state_q == ST_RUN) && (hold_q == HOLD_LAST);
        miss_s   = (Q != mux_ref(d_q, s_q));
        last_s   = (s_q == 2'd3) && (d_q == 4'hF);
        hold_d   = hold_q + {{(CNT_W-1){1'b0}}, 1'b1};
        err_d    = err_q + 7'd1;
        if (s_q == 2'd3) begin
            s_d = 2'd0;
            d_d = d_q + 4'd1;
        end else begin
            s_d = s_q + 2'd1;
            d_d = d_q;
        end
    end

    // Sweep controller: IDLE/DONE wait for START, RUN holds and samples each vector.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            s_q        <= 2'd0;
            d_q        <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= 7'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    mismatch_q <= 1'b0;
                    if (START) begin
                        state_q <= ST_RUN;
                        hold_q  <= '0;
                        s_q     <= 2'd0;
                        d_q     <= 4'd0;
                        err_q   <= 7'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RUN: begin
                    if (sample_s) begin
                        hold_q     <= '0;
                        mismatch_q <= miss_s;
                        if (miss_s) begin
                            err_q <= err_d;
                        end else begin
                            err_q <= err_q;
                        end
                        // The last vector's advance wraps S and D back to zero.
                        s_q <= s_d;
                        d_q <= d_d;
                        if (last_s) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        hold_q     <= hold_d;
                        mismatch_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    hold_q     <= '0;
                    s_q        <= 2'd0;
                    d_q        <= 4'd0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    mismatch_q <= 1'b0;
                    err_q      <= 7'd0;
                end
            endcase
        end
    end

    assign S        = s_q;
    assign D        = d_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign MISMATCH = mismatch_q;
    assign ERR_CNT  = err_q;

endmodule
